// File: rtl/wb_multi_stage_pkg.sv
// Shared stall-bus encoding and width helpers for the writeback stage.
// Stall bits: 4 is this stage, 5 is the next stage; a set bit means stop.
package wb_multi_stage_pkg;

  localparam int   STALL_W    = 6;
  localparam int   STALL_SELF = 4;
  localparam int   STALL_NEXT = 5;
  localparam logic STOP       = 1'b1;
  localparam logic NO_STOP    = 1'b0;

  // One forwarding lane: {we, waddr, wdata}
  function automatic int fwd_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

  // One trace entry: {we, waddr, wdata, pc}
  function automatic int trace_w(input int addr_w, input int data_w, input int pc_w);
    return 1 + addr_w + data_w + pc_w;
  endfunction

endpackage

// File: rtl/wb_trace_fifo.sv
// Multi-push (up to NPUSH in lane order), single-pop FIFO; head is combinational from the read pointer.
// Latency: one edge from push to head; pushes beyond free space drop highest lanes first and set sticky overflow.
module wb_trace_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int NPUSH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NPUSH-1:0]          push,
  input  logic [NPUSH*W-1:0]        push_data,
  input  logic                      pop,
  output logic [W-1:0]              head,
  output logic [$clog2(DEPTH):0]    count,
  output logic [$clog2(DEPTH):0]    free,
  output logic                      overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] cnt;
  logic [NPUSH-1:0] accept;
  logic [PW-1:0] slot [NPUSH];
  logic [CW-1:0] n_acc;
  logic          drop;
  logic          do_pop;

  assign free   = CW'(DEPTH) - cnt;
  assign count  = cnt;
  assign head   = mem[rptr];
  assign do_pop = pop & (cnt != '0);

  // Space is judged before this edge's pop, so a full FIFO never overwrites its head.
  always_comb begin
    n_acc = '0;
    drop  = 1'b0;
    for (int i = 0; i < NPUSH; i++) begin
      accept[i] = 1'b0;
      slot[i]   = wptr + n_acc[PW-1:0];
      if (push[i]) begin
        if (n_acc < free) begin
          accept[i] = 1'b1;
          n_acc     = n_acc + 1'b1;
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NPUSH; i++)
      if (accept[i]) mem[slot[i]] <= push_data[i*W +: W];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      wptr <= wptr + n_acc[PW-1:0];
      rptr <= rptr + PW'(do_pop);
      cnt  <= cnt + n_acc - CW'(do_pop);
      if (drop) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/wb_multi_stage.sv
// Writeback stage: registers LANES retirements, drives RF writes/forwarding (rf in load cycle), trace head one cycle later.
// Backpressure: trace_stall_req when the trace FIFO cannot take a full group; WB_RETIRE_CNT_EN adds retired_cnt.
module wb_multi_stage
  import wb_multi_stage_pkg::*;
#(
  parameter int LANES       = 2,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int PC_W        = 32,
  parameter int TRACE_DEPTH = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [STALL_W-1:0]                    stall,
  input  logic [LANES-1:0]                      in_valid,
  input  logic [LANES-1:0]                      in_we,
  input  logic [LANES*ADDR_W-1:0]               in_waddr,
  input  logic [LANES*DATA_W-1:0]               in_wdata,
  input  logic [LANES*PC_W-1:0]                 in_pc,
  output logic [LANES-1:0]                      rf_we,
  output logic [LANES*ADDR_W-1:0]               rf_waddr,
  output logic [LANES*DATA_W-1:0]               rf_wdata,
  output logic [LANES*(1+ADDR_W+DATA_W)-1:0]    wb_to_id_forwarding,
  output logic                                  trace_stall_req,
  output logic                                  trace_overflow,
  output logic [PC_W-1:0]                       debug_wb_pc,
  output logic [3:0]                            debug_wb_rf_wen,
  output logic [ADDR_W-1:0]                     debug_wb_rf_wnum,
  output logic [DATA_W-1:0]                     debug_wb_rf_wdata,
  output logic [31:0]                           retired_cnt
);

  localparam int FW = fwd_w(ADDR_W, DATA_W);
  localparam int TW = trace_w(ADDR_W, DATA_W, PC_W);
  localparam int CW = $clog2(TRACE_DEPTH) + 1;

  logic [LANES-1:0]        st_valid;
  logic [LANES-1:0]        st_we;
  logic [LANES*ADDR_W-1:0] st_waddr;
  logic [LANES*DATA_W-1:0] st_wdata;
  logic [LANES*PC_W-1:0]   st_pc;
  logic                    fresh;

  logic [LANES*TW-1:0] trace_in;
  logic [TW-1:0]       trace_head;
  logic [CW-1:0]       trace_count;
  logic [CW-1:0]       trace_free;
  logic                trace_empty;
  logic                head_we;
  logic [ADDR_W-1:0]   head_waddr;
  logic [DATA_W-1:0]   head_wdata;
  logic [PC_W-1:0]     head_pc;
  logic                unused_stall;

  assign unused_stall = ^stall[3:0];

  // fresh marks a newly loaded group so a held register is traced only once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_valid <= '0;
      st_we    <= '0;
      st_waddr <= '0;
      st_wdata <= '0;
      st_pc    <= '0;
      fresh    <= 1'b0;
    end else if (stall[STALL_SELF] == NO_STOP) begin
      st_valid <= in_valid;
      st_we    <= in_we;
      st_waddr <= in_waddr;
      st_wdata <= in_wdata;
      st_pc    <= in_pc;
      fresh    <= |in_valid;
    end else if (stall[STALL_NEXT] == NO_STOP) begin
      st_valid <= '0;
      st_we    <= '0;
      st_waddr <= '0;
      st_wdata <= '0;
      st_pc    <= '0;
      fresh    <= 1'b0;
    end else begin
      fresh    <= 1'b0;
    end
  end

  // Youngest lane wins a same-address conflict.
  always_comb begin
    rf_we = '0;
    for (int i = 0; i < LANES; i++) begin
      rf_we[i] = st_valid[i] & st_we[i];
      for (int j = i + 1; j < LANES; j++)
        if (st_valid[j] && st_we[j] &&
            st_waddr[j*ADDR_W +: ADDR_W] == st_waddr[i*ADDR_W +: ADDR_W])
          rf_we[i] = 1'b0;
    end
  end

  assign rf_waddr = st_waddr;
  assign rf_wdata = st_wdata;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign wb_to_id_forwarding[i*FW +: FW] =
      {rf_we[i], st_waddr[i*ADDR_W +: ADDR_W], st_wdata[i*DATA_W +: DATA_W]};
    assign trace_in[i*TW +: TW] =
      {st_we[i], st_waddr[i*ADDR_W +: ADDR_W], st_wdata[i*DATA_W +: DATA_W], st_pc[i*PC_W +: PC_W]};
  end

  wb_trace_fifo #(
    .W     (TW),
    .DEPTH (TRACE_DEPTH),
    .NPUSH (LANES)
  ) u_trace_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (st_valid & {LANES{fresh}}),
    .push_data (trace_in),
    .pop       (1'b1),
    .head      (trace_head),
    .count     (trace_count),
    .free      (trace_free),
    .overflow  (trace_overflow)
  );

  assign trace_empty = (trace_count == '0);
  // free < LANES is the same condition as count > TRACE_DEPTH - LANES.
  assign trace_stall_req = (trace_free < CW'(LANES));

  assign {head_we, head_waddr, head_wdata, head_pc} = trace_head;
  assign debug_wb_pc       = trace_empty ? '0 : head_pc;
  assign debug_wb_rf_wen   = {4{head_we & ~trace_empty}};
  assign debug_wb_rf_wnum  = trace_empty ? '0 : head_waddr;
  assign debug_wb_rf_wdata = trace_empty ? '0 : head_wdata;

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       retired_cnt <= '0;
    else if (fresh) retired_cnt <= retired_cnt + 32'($countones(st_valid));
  end
`else
  assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_wb_multi_stage.sv
// Directed bench for wb_multi_stage: queue-based trace model checked every negedge, plus literal checkpoints.
module tb_wb_multi_stage;

  localparam int LANES = 2;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic [1:0]  in_valid, in_we;
  logic [9:0]  in_waddr;
  logic [63:0] in_wdata, in_pc;
  logic [1:0]  rf_we;
  logic [9:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic [75:0] wb_to_id_forwarding;
  logic        trace_stall_req, trace_overflow;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  logic [31:0] retired_cnt;

  wb_multi_stage #(.LANES(LANES), .DATA_W(32), .ADDR_W(5), .PC_W(32), .TRACE_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .stall(stall), .in_valid(in_valid), .in_we(in_we),
    .in_waddr(in_waddr), .in_wdata(in_wdata), .in_pc(in_pc),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .wb_to_id_forwarding(wb_to_id_forwarding),
    .trace_stall_req(trace_stall_req), .trace_overflow(trace_overflow),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .retired_cnt(retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        v;
    logic        we;
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] pc;
  } lane_t;

  lane_t       m_lane [LANES];
  lane_t       q [$];
  bit          m_fresh;
  bit          m_ovf;
  int unsigned m_cnt;
  bit          chk_en = 1'b0;

  task automatic model_reset();
    for (int i = 0; i < LANES; i++) m_lane[i] = '0;
    q.delete();
    m_fresh = 1'b0;
    m_ovf   = 1'b0;
    m_cnt   = 0;
  endtask

  // One clock edge of the stage as seen from outside: trace retire/accept, then the stage register update.
  task automatic model_edge();
    lane_t pend [$];
    int    room;
    if (m_fresh)
      for (int i = 0; i < LANES; i++) if (m_lane[i].v) pend.push_back(m_lane[i]);
    m_cnt += pend.size();
    room = DEPTH - q.size();
    if (q.size() != 0) void'(q.pop_front());
    foreach (pend[k]) begin
      if (k < room) q.push_back(pend[k]);
      else          m_ovf = 1'b1;
    end
    if (stall[4] == 1'b0) begin
      for (int i = 0; i < LANES; i++)
        m_lane[i] = {in_valid[i], in_we[i], in_waddr[i*5 +: 5], in_wdata[i*32 +: 32], in_pc[i*32 +: 32]};
      m_fresh = |in_valid;
    end else if (stall[5] == 1'b0) begin
      for (int i = 0; i < LANES; i++) m_lane[i] = '0;
      m_fresh = 1'b0;
    end else begin
      m_fresh = 1'b0;
    end
  endtask

  function automatic logic [LANES-1:0] exp_rf_we();
    bit taken [32];
    logic [LANES-1:0] r;
    r = '0;
    foreach (taken[k]) taken[k] = 1'b0;
    for (int i = LANES - 1; i >= 0; i--)
      if (m_lane[i].v && m_lane[i].we) begin
        if (!taken[m_lane[i].a]) r[i] = 1'b1;
        taken[m_lane[i].a] = 1'b1;
      end
    return r;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      logic [LANES-1:0] ew;
      lane_t            hd;
      ew = exp_rf_we();
      hd = (q.size() != 0) ? q[0] : lane_t'('0);
      chk("rf_we", rf_we, ew);
      chk("rf_waddr", rf_waddr, {m_lane[1].a, m_lane[0].a});
      chk("rf_wdata", rf_wdata, {m_lane[1].d, m_lane[0].d});
      chk("fwd", wb_to_id_forwarding, {ew[1], m_lane[1].a, m_lane[1].d, ew[0], m_lane[0].a, m_lane[0].d});
      chk("stall_req", trace_stall_req, q.size() > DEPTH - LANES);
      chk("overflow", trace_overflow, m_ovf);
      chk("dbg_pc", debug_wb_pc, hd.pc);
      chk("dbg_wen", debug_wb_rf_wen, {4{hd.we}});
      chk("dbg_wnum", debug_wb_rf_wnum, hd.a);
      chk("dbg_wdata", debug_wb_rf_wdata, hd.d);
`ifdef WB_RETIRE_CNT_EN
      chk("retired_cnt", retired_cnt, m_cnt);
`else
      chk("retired_cnt", retired_cnt, 32'd0);
`endif
    end
  end

  task automatic step(input logic [5:0] st, input logic [1:0] v, input logic [1:0] we,
                      input logic [4:0] a0, input logic [4:0] a1,
                      input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] p0);
    stall    = st;
    in_valid = v;
    in_we    = we;
    in_waddr = {a1, a0};
    in_wdata = {d1, d0};
    in_pc    = {p0 + 32'd4, p0};
    @(posedge clk);
    model_edge();
    #2;
  endtask

  task automatic idle();
    step(6'd0, 2'b00, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
  endtask

  int seen;

  initial begin
    rst = 1'b0;
    stall = '0; in_valid = '0; in_we = '0; in_waddr = '0; in_wdata = '0; in_pc = '0;
    model_reset();
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset rf_we", rf_we, 2'b00);
    chk("reset dbg_pc", debug_wb_pc, 32'd0);
    chk("reset stall_req", trace_stall_req, 1'b0);
    chk("reset overflow", trace_overflow, 1'b0);
    chk("reset cnt", retired_cnt, 32'd0);
    rst = 1'b1;

    // Independent writes
    step(6'd0, 2'b11, 2'b11, 5'd3, 5'd4, 32'h11, 32'h22, 32'hBFC00000);
    chk("t1 rf_we", rf_we, 2'b11);
    chk("t1 rf_wdata", rf_wdata, {32'h22, 32'h11});
    idle();
    chk("t1 head0 wnum", debug_wb_rf_wnum, 5'd3);
    chk("t1 head0 wdata", debug_wb_rf_wdata, 32'h11);
    chk("t1 head0 pc", debug_wb_pc, 32'hBFC00000);
    chk("t1 head0 wen", debug_wb_rf_wen, 4'hF);
    idle();
    chk("t1 head1 wnum", debug_wb_rf_wnum, 5'd4);
    chk("t1 head1 pc", debug_wb_pc, 32'hBFC00004);
    idle();
    chk("t1 drained wen", debug_wb_rf_wen, 4'h0);

    // Same-address conflict
    step(6'd0, 2'b11, 2'b11, 5'd5, 5'd5, 32'hA, 32'hB, 32'h100);
    chk("t2 rf_we", rf_we, 2'b10);
    chk("t2 lane1 data", rf_wdata[63:32], 32'hB);
    chk("t2 fwd lane0 we", wb_to_id_forwarding[37], 1'b0);
    chk("t2 fwd lane1 we", wb_to_id_forwarding[75], 1'b1);
    idle();
    chk("t2 trace0", {debug_wb_rf_wen, debug_wb_rf_wdata}, {4'hF, 32'hA});
    idle();
    chk("t2 trace1", {debug_wb_rf_wen, debug_wb_rf_wdata}, {4'hF, 32'hB});
    idle();

    // Hold for three cycles, then bubble
    seen = 0;
    step(6'd0, 2'b11, 2'b11, 5'd6, 5'd7, 32'h33, 32'h44, 32'h200);
    if (debug_wb_rf_wen != 4'h0) seen++;
    for (int k = 0; k < 3; k++) begin
      step(6'b110000, 2'b11, 2'b11, 5'd8, 5'd9, 32'h55, 32'h66, 32'h300);
      if (debug_wb_rf_wen != 4'h0) seen++;
    end
    chk("t3 held waddr", rf_waddr, {5'd7, 5'd6});
    chk("t3 held we", rf_we, 2'b11);
    step(6'b010000, 2'b11, 2'b11, 5'd8, 5'd9, 32'h55, 32'h66, 32'h300);
    if (debug_wb_rf_wen != 4'h0) seen++;
    chk("t3 bubble rf_we", rf_we, 2'b00);
    for (int k = 0; k < 2; k++) begin
      idle();
      if (debug_wb_rf_wen != 4'h0) seen++;
    end
    chk("t3 trace entries", seen, 2);

    // Backpressure ignored: overflow
    for (int k = 0; k < 4; k++) begin
      step(6'd0, 2'b11, 2'b11, 5'd10, 5'd11, 32'h70 + k, 32'h80 + k, 32'h400);
      if (k == 2) begin
        chk("t4 stall_req", trace_stall_req, 1'b1);
        chk("t4 no ovf yet", trace_overflow, 1'b0);
      end
    end
    chk("t4 overflow", trace_overflow, 1'b1);
    repeat (5) idle();
    chk("t4 ovf sticky", trace_overflow, 1'b1);
    chk("t4 stall_req off", trace_stall_req, 1'b0);

    // Async reset with three entries queued
    for (int k = 0; k < 3; k++)
      step(6'd0, 2'b11, 2'b11, 5'd12, 5'd13, 32'h90 + k, 32'hA0 + k, 32'h500);
    chk("t5 pre stall_req", trace_stall_req, 1'b1);
    rst = 1'b0;
    model_reset();
    #1;
    chk("t5 rst rf_we", rf_we, 2'b00);
    chk("t5 rst rf_wdata", rf_wdata, 64'd0);
    chk("t5 rst fwd", wb_to_id_forwarding, 76'd0);
    chk("t5 rst dbg", {debug_wb_rf_wen, debug_wb_pc, debug_wb_rf_wdata}, 68'd0);
    chk("t5 rst stall_req", trace_stall_req, 1'b0);
    chk("t5 rst ovf", trace_overflow, 1'b0);
    chk("t5 rst cnt", retired_cnt, 32'd0);
    #1 rst = 1'b1;
    idle();
    chk("t5 post wen", debug_wb_rf_wen, 4'h0);
    chk("t5 post stall_req", trace_stall_req, 1'b0);

    // Retirement counter
    for (int k = 0; k < 10; k++)
      step(6'd0, 2'b11, 2'b01, 5'd14, 5'd15, 32'hC0 + k, 32'hD0 + k, 32'h600);
    step(6'd0, 2'b01, 2'b01, 5'd16, 5'd0, 32'hE0, 32'h0, 32'h700);
    idle();
`ifdef WB_RETIRE_CNT_EN
    chk("t6 retired_cnt", retired_cnt, 32'd21);
`else
    chk("t6 retired_cnt", retired_cnt, 32'd0);
`endif
    repeat (6) idle();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
